secam_decoder: RTL and testbench
================================

# secam_decoder

Recovers the Db and Dr color-difference values from a SECAM FM chroma sample stream, the receive-side counterpart to the SECAM chroma encoder. It sits after chroma band separation in the loopback and test path. Each rising zero crossing is detected with hysteresis, and the clocks spanning a fixed number of carrier cycles are measured. That period is compared against the Db or Dr rest-frequency reference and scaled to a signed 8-bit value. A per-component hold register stands in for the receiver's one-line delay, so Db and Dr are both available on every line.

## Interface
- MEAS_CYCLES, 4: carrier cycles per measurement (1..8).
- HYST, 8: zero-crossing hysteresis threshold, chroma units (0..63).
- DB_REF_Q4, 723: expected tick count for MEAS_CYCLES cycles at 4.250 MHz, Q8.4, 48 MHz clock.
- DR_REF_Q4, 697: same for 4.40625 MHz.
- GAIN, 16: unsigned 6-bit scale applied to the period error.
- SMOOTH_SHIFT, 0: first-order output smoothing shift (0 = off, max 4).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- chroma  in  8 signed  FM chroma sample, one per clk.
- enabled  in  1  chroma window active (burst/active video).
- even_line  in  1  1 = Db line, 0 = Dr line.
- db  out  8 signed  recovered Db, held between updates.
- dr  out  8 signed  recovered Dr, held between updates.
- meas_valid  out  1  one-cycle pulse when db or dr updates.
- carrier_ok  out  1  carrier present (last measurement completed without timeout).

## Operation
- Stage S0: chroma registered. S1: hysteresis state set when S0 > HYST, cleared when S0 < -HYST, otherwise held. rise = low→high transition of the hysteresis state, registered.
- FSM states: IDLE, ARM, MEASURE.
  - IDLE: wait for enabled=1, then go to ARM.
  - ARM: on rise, clear ticks to 0 and cycles to 0, then go to MEASURE.
  - MEASURE: ticks increments every cycle and saturates at 255. Each rise increments cycles. On the rise that makes cycles == MEAS_CYCLES, close the measurement: latch ticks+1, latch the current even_line, restart ticks=0 and cycles=0, and stay in MEASURE. Back-to-back measurements share their boundary crossing.
- Timeout: ticks reaching 255 clears carrier_ok, discards the measurement and goes to ARM. A completed measurement sets carrier_ok.
- Abort: enabled=0 in any state goes to IDLE, discards the in-flight measurement, and leaves outputs held. A change of even_line while in MEASURE goes to ARM with no output. A change on the same cycle as a closing rise also discards that measurement.
- Arithmetic (signed, widths explicit):
  - m = ticks<<4, 12 bits.
  - Db: e = DB_REF_Q4 − m. Dr: e = m − DR_REF_Q4. e is 13 bits.
  - p = e·GAIN, 20 bits.
  - r = p>>>4 (arithmetic), then clamp to [−128, 127].
  - Smoothing: y ← y + ((r − y)>>>SMOOTH_SHIFT), 9-bit intermediate, result stored in 8 bits.
  - The latched line flag selects whether db or dr is updated. The other output holds its value.
- Reset (rst_n=0 sampled): db=0, dr=0, meas_valid=0, carrier_ok=0, FSM=IDLE, hysteresis state=low, all pipeline registers 0. Reset has priority over every other event.

## Timing
- Measurement closes at edge k+2, where edge k sampled the chroma value completing the closing crossing.
- Error/gain stage at k+3. Clamp/smooth and output register at k+4. meas_valid is high for the single cycle after edge k+4, with db/dr already updated.
- Steady-state update rate is one measurement per MEAS_CYCLES carrier cycles.
- Outputs change only on meas_valid or reset.

## Test plan
- Reset: rst_n=0 for 2 cycles with random chroma → db=0, dr=0, meas_valid=0, carrier_ok=0. After release, no meas_valid for at least MEAS_CYCLES+1 crossings.
- Db lock: enabled=1, even_line=1, chroma square wave +60 for 6 cycles / −60 for 5 (period 11) → each measurement ticks=44, m=704, db=19. carrier_ok=1, dr stays 0. meas_valid pulses every 44 cycles, 4 cycles after the closing sample.
- Dr with hold: continue from the previous case with even_line=0, same input → dr=7, db stays 19. The first measurement after the toggle is discarded.
- Clamp: even_line=1, period 20 → m=1280, e=−557 → db=−128. even_line=0, period 8 → m=512, e=−185, r=−185 → dr=−128.
- Carrier loss/abort:
  - chroma=0 for 300 cycles → carrier_ok falls once ticks reaches 255, outputs hold, no meas_valid.
  - Dropping enabled mid-measurement → no meas_valid, FSM in IDLE.
- Smoothing: SMOOTH_SHIFT=1, period 11, even_line=1 from reset → db sequence 9, 14, 16, 17, 18, 18.

Source files
------------

// File: rtl/secam_decoder.sv
// SECAM FM chroma decoder: times MEAS_CYCLES carrier periods between hysteresis
// zero crossings and maps the period error onto signed 8-bit Db or Dr.
module secam_decoder #(
  parameter int MEAS_CYCLES  = 4,
  parameter int HYST         = 8,
  parameter int DB_REF_Q4    = 723,
  parameter int DR_REF_Q4    = 697,
  parameter int GAIN         = 16,
  parameter int SMOOTH_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic signed [7:0] chroma,
  input  logic              enabled,
  input  logic              even_line,
  output logic signed [7:0] db,
  output logic signed [7:0] dr,
  output logic              meas_valid,
  output logic              carrier_ok,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, MEASURE = 2'd2} state_e;

  localparam logic signed [7:0]  HYST_POS   = 8'(HYST);
  localparam logic signed [7:0]  HYST_NEG   = 8'(-HYST);
  localparam logic [3:0]         LAST_CYCLE = 4'(MEAS_CYCLES - 1);
  localparam logic signed [12:0] DB_REF     = 13'(DB_REF_Q4);
  localparam logic signed [12:0] DR_REF     = 13'(DR_REF_Q4);
  localparam logic signed [19:0] GAIN_S     = 20'(GAIN);

  // Front end: registered sample, hysteresis slicer, registered rising edge.
  logic signed [7:0] s0_q;
  logic              hyst_q, hyst_d, rise_q;

  always_comb begin
    hyst_d = hyst_q;
    if (s0_q > HYST_POS)      hyst_d = 1'b1;
    else if (s0_q < HYST_NEG) hyst_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_q   <= '0;
      hyst_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s0_q   <= chroma;
      hyst_q <= hyst_d;
      rise_q <= hyst_d & ~hyst_q;
    end
  end

  // Period measurement FSM.
  state_e     state_q, state_d;
  logic [7:0] ticks_q, ticks_d, close_ticks_q, close_ticks_d;
  logic [3:0] cycles_q, cycles_d;
  logic       carrier_q, carrier_d, close_q, close_d;
  logic       close_line_q, close_line_d, el_prev_q;
  logic       line_chg;

  assign line_chg = even_line != el_prev_q;

  always_comb begin
    state_d       = state_q;
    ticks_d       = ticks_q;
    cycles_d      = cycles_q;
    carrier_d     = carrier_q;
    close_d       = 1'b0;
    close_ticks_d = close_ticks_q;
    close_line_d  = close_line_q;
    if (!enabled) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (rise_q) begin
            ticks_d  = '0;
            cycles_d = '0;
            state_d  = MEASURE;
          end
        end
        MEASURE: begin
          if (line_chg) begin
            state_d = ARM;
          end else if (ticks_q == 8'hFF) begin
            state_d   = ARM;
            carrier_d = 1'b0;
          end else if (rise_q && cycles_q == LAST_CYCLE) begin
            // The closing crossing also opens the next measurement.
            close_d       = 1'b1;
            close_ticks_d = ticks_q + 8'd1;
            close_line_d  = even_line;
            carrier_d     = 1'b1;
            ticks_d       = '0;
            cycles_d      = '0;
          end else begin
            ticks_d = ticks_q + 8'd1;
            if (rise_q) cycles_d = cycles_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ticks_q       <= '0;
      cycles_q      <= '0;
      carrier_q     <= 1'b0;
      close_q       <= 1'b0;
      close_ticks_q <= '0;
      close_line_q  <= 1'b0;
      el_prev_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ticks_q       <= ticks_d;
      cycles_q      <= cycles_d;
      carrier_q     <= carrier_d;
      close_q       <= close_d;
      close_ticks_q <= close_ticks_d;
      close_line_q  <= close_line_d;
      el_prev_q     <= even_line;
    end
  end

  // Error and gain stage; Db runs inverted relative to Dr.
  logic signed [12:0] m_s, e_d;
  logic signed [19:0] p_d, p_q;
  logic               p_valid_q, p_line_q;

  assign m_s = {1'b0, close_ticks_q, 4'b0000};

  always_comb begin
    e_d = close_line_q ? (DB_REF - m_s) : (m_s - DR_REF);
    p_d = $signed({{7{e_d[12]}}, e_d}) * GAIN_S;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q       <= '0;
      p_valid_q <= 1'b0;
      p_line_q  <= 1'b0;
    end else begin
      p_q       <= p_d;
      p_valid_q <= close_q;
      p_line_q  <= close_line_q;
    end
  end

  // Clamp, smoothing and per-component hold registers.
  logic signed [19:0] r_full;
  logic signed [7:0]  r_clamp, y_old, y_new, db_q, dr_q;
  logic signed [8:0]  diff, step, y_sum;
  logic               meas_valid_q;

  always_comb begin
    r_full = p_q >>> 4;
    if (r_full > 20'sd127)       r_clamp = 8'sd127;
    else if (r_full < -20'sd128) r_clamp = -8'sd128;
    else                         r_clamp = 8'(r_full);
    y_old = p_line_q ? db_q : dr_q;
    diff  = {r_clamp[7], r_clamp} - {y_old[7], y_old};
    step  = diff >>> SMOOTH_SHIFT;
    y_sum = {y_old[7], y_old} + step;
    y_new = 8'(y_sum);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_q         <= '0;
      dr_q         <= '0;
      meas_valid_q <= 1'b0;
    end else begin
      meas_valid_q <= p_valid_q;
      if (p_valid_q) begin
        if (p_line_q) db_q <= y_new;
        else          dr_q <= y_new;
      end
    end
  end

  assign db         = db_q;
  assign dr         = dr_q;
  assign meas_valid = meas_valid_q;
  assign carrier_ok = carrier_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_secam_decoder.sv
// Directed bench for secam_decoder: square-wave chroma phases feed a scoreboard;
// a second instance with SMOOTH_SHIFT=1 shares the stimulus for the first phase.
`timescale 1ns/1ps
module tb_secam_decoder;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [7:0] chroma = '0;
  logic              enabled = 1'b0;
  logic              even_line = 1'b0;
  logic signed [7:0] db0, dr0, db1, dr1;
  logic              mv0, mv1, ok0, ok1;
  logic [1:0]        st0, st1;

  secam_decoder dut0 (
    .clk(clk), .rst_n(rst_n), .chroma(chroma), .enabled(enabled),
    .even_line(even_line), .db(db0), .dr(dr0), .meas_valid(mv0),
    .carrier_ok(ok0), .state_o(st0)
  );

  secam_decoder #(.SMOOTH_SHIFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .chroma(chroma), .enabled(enabled),
    .even_line(even_line), .db(db1), .dr(dr1), .meas_valid(mv1),
    .carrier_ok(ok1), .state_o(st1)
  );

  // Scoreboard
  logic [15:0] exp_q[$];
  logic [15:0] exp1_q[$];
  int          gap_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          seen0 = 0;
  int          mark = 0;
  bit          chk1 = 1'b0;
  logic [15:0] e0, e1;
  int          g0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int d, input int r, input int g);
    exp_q.push_back({8'(d), 8'(r)});
    gap_q.push_back(g);
  endtask

  // Monitor: valid means db/dr are already updated.
  always @(negedge clk) begin
    if (mv0 === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e0 = exp_q.pop_front();
        g0 = gap_q.pop_front();
        check("db", db0, $signed(e0[15:8]));
        check("dr", dr0, $signed(e0[7:0]));
        check("carrier_ok_at_pulse", ok0, 1);
        if (g0 != 0) check("pulse_gap", cyc - mark, g0);
      end
      mark = cyc;
      seen0++;
    end
    if (mv1 === 1'b1 && chk1) begin
      if (exp1_q.size() == 0) begin
        check("unexpected_pulse_smooth", 1, 0);
      end else begin
        e1 = exp1_q.pop_front();
        check("db_smooth", db1, $signed(e1[15:8]));
        check("dr_smooth", dr1, $signed(e1[7:0]));
      end
    end
  end

  // Chroma driver
  bit                wave_on = 1'b0;
  bit                rand_on = 1'b1;
  int                wave_period = 11;
  int                ph = 0;
  logic signed [7:0] idle_level = -8'sd60;

  initial forever begin
    @(negedge clk);
    if (rand_on) begin
      chroma = 8'($urandom_range(0, 255));
    end else if (wave_on) begin
      chroma = (ph < (wave_period + 1) / 2) ? 8'sd60 : -8'sd60;
      ph = (ph + 1 == wave_period) ? 0 : ph + 1;
    end else begin
      chroma = idle_level;
    end
  end

  task automatic restart(input bit line, input int period);
    @(posedge clk); #1;
    enabled = 1'b0;
    wave_on = 1'b0;
    idle_level = -8'sd60;
    repeat (4) @(posedge clk);
    #1;
    even_line = line;
    enabled = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    wave_period = period;
    ph = 0;
    mark = cyc;
    wave_on = 1'b1;
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int n;
    n = 0;
    while (seen0 < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("pulse_wait", (seen0 >= target) ? 1 : 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    even_line = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_db", db0, 0);
    check("rst_dr", dr0, 0);
    check("rst_meas_valid", mv0, 0);
    check("rst_carrier_ok", ok0, 0);
    check("rst_state", st0, 0);
    check("rst_db_smooth", db1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rand_on = 1'b0;

    // Db lock: period 11 -> ticks 44 -> db 19; smoothed instance converges.
    restart(1'b1, 11);
    push_exp(19, 0, 49);
    repeat (5) push_exp(19, 0, 44);
    exp1_q.push_back({8'sd9, 8'sd0});
    exp1_q.push_back({8'sd14, 8'sd0});
    exp1_q.push_back({8'sd16, 8'sd0});
    exp1_q.push_back({8'sd17, 8'sd0});
    exp1_q.push_back({8'sd18, 8'sd0});
    exp1_q.push_back({8'sd18, 8'sd0});
    chk1 = 1'b1;
    wait_pulses(6, 400);
    chk1 = 1'b0;

    // Dr with hold: the measurement spanning the toggle is dropped.
    even_line = 1'b0;
    push_exp(19, 7, 55);
    push_exp(19, 7, 44);
    wait_pulses(8, 300);

    // Clamp at both ends of the range.
    restart(1'b1, 20);
    push_exp(-128, 7, 85);
    push_exp(-128, 7, 80);
    wait_pulses(10, 400);
    restart(1'b0, 8);
    push_exp(-128, -128, 37);
    push_exp(-128, -128, 32);
    wait_pulses(12, 300);

    // Carrier loss: no crossings until ticks saturate.
    check("carrier_ok_before_loss", ok0, 1);
    @(posedge clk); #1;
    wave_on = 1'b0;
    idle_level = 8'sd0;
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("carrier_ok_after_loss", ok0, 0);
    check("db_hold_loss", db0, -128);
    check("dr_hold_loss", dr0, -128);
    check("state_after_loss", st0, 1);

    // Abort: drop enabled mid-measurement.
    restart(1'b1, 11);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("state_mid_measure", st0, 2);
    @(posedge clk); #1;
    enabled = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("state_after_abort", st0, 0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("carrier_ok_after_abort", ok0, 0);
    check("db_hold_abort", db0, -128);
    check("dr_hold_abort", dr0, -128);

    check("exp_queue_left", exp_q.size(), 0);
    check("exp1_queue_left", exp1_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
